// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST controller.
package mbist_pkg;

  typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE} state_e;
  typedef enum logic [1:0] {W0, W1, R0, R1} op_e;
  typedef enum logic {UP, DOWN} dir_e;

  typedef struct packed {
    dir_e       dir;
    op_e        op0;
    op_e        op1;
    logic [1:0] n_ops;
  } elem_t;

  localparam int         NUM_ELEMS = 6;
  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEMS - 1);

  // Single-op elements carry a don't-care op1 that is never reached.
  localparam elem_t MARCH_TBL [NUM_ELEMS] = '{
    '{UP,   W0, W0, 2'd1},
    '{UP,   R0, W1, 2'd2},
    '{UP,   R1, W0, 2'd2},
    '{DOWN, R0, W1, 2'd2},
    '{DOWN, R1, W0, 2'd2},
    '{UP,   R0, W0, 2'd1}
  };

  function automatic logic op_is_wr(input op_e op);
    return (op == W0) || (op == W1);
  endfunction

  function automatic logic op_bit(input op_e op);
    return (op == W1) || (op == R1);
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter; is_last flags the end of the current sweep.
module mbist_addr_gen
  import mbist_pkg::*;
#(
  parameter int A_W       = 16,
  parameter int LAST_ADDR = 15
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           load,
  input  logic [A_W-1:0] load_val,
  input  logic           step,
  input  dir_e           dir,
  output logic [A_W-1:0] addr,
  output logic           is_last
);

  assign is_last = (dir == UP) ? (addr == A_W'(LAST_ADDR)) : (addr == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst)     addr <= '0;
    else if (load) addr <= load_val;
    else if (step) addr <= (dir == UP) ? addr + 1'b1 : addr - 1'b1;
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: sequences writes/reads, compares, latches first failure.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int D_W       = 32,
  parameter int A_W       = 16,
  parameter int LAST_ADDR = 15
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_fail,
  output logic [A_W-1:0] o_fail_addr,
  output logic [D_W-1:0] o_fail_data,
  output logic [D_W-1:0] o_fail_exp,
  output logic [D_W-1:0] o_mem_data,
  output logic [A_W-1:0] o_mem_addr,
  output logic           o_mem_en,
  output logic           o_mem_wr_rbar,
  input  logic [D_W-1:0] i_mem_out
);

  state_e         state, state_nx;
  logic [2:0]     elem, elem_nx, elem_inc;
  logic           op_idx, op_idx_nx;
  elem_t          cur;
  op_e            cur_op;
  logic [D_W-1:0] pat;
  logic           mismatch, advance;

  logic           ag_load, ag_step, is_last;
  logic [A_W-1:0] ag_load_val, addr;

  assign elem_inc = elem + 3'd1;
  assign cur      = MARCH_TBL[elem];
  assign cur_op   = op_idx ? cur.op1 : cur.op0;
  assign pat      = {D_W{op_bit(cur_op)}};
  assign mismatch = (state == CMP) && (i_mem_out != pat);
  assign advance  = (state == WR) || ((state == CMP) && !mismatch);

  mbist_addr_gen #(.A_W(A_W), .LAST_ADDR(LAST_ADDR)) u_addr_gen (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .load     (ag_load),
    .load_val (ag_load_val),
    .step     (ag_step),
    .dir      (cur.dir),
    .addr     (addr),
    .is_last  (is_last)
  );

  always_comb begin
    state_nx    = state;
    elem_nx     = elem;
    op_idx_nx   = op_idx;
    ag_load     = 1'b0;
    ag_load_val = '0;
    ag_step     = 1'b0;
    case (state)
      IDLE: if (i_start) begin
        state_nx  = WR;
        elem_nx   = '0;
        op_idx_nx = 1'b0;
        ag_load   = 1'b1;
      end
      RD:   state_nx = CMP;
      CMP:  if (mismatch) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: ;
    endcase
    // Order of progress: next op at this address, next address, next element, finish.
    if (advance) begin
      if (!op_idx && cur.n_ops == 2'd2) begin
        op_idx_nx = 1'b1;
        state_nx  = op_is_wr(cur.op1) ? WR : RD;
      end else if (!is_last) begin
        op_idx_nx = 1'b0;
        ag_step   = 1'b1;
        state_nx  = op_is_wr(cur.op0) ? WR : RD;
      end else if (elem != LAST_ELEM) begin
        elem_nx     = elem_inc;
        op_idx_nx   = 1'b0;
        ag_load     = 1'b1;
        ag_load_val = (MARCH_TBL[elem_inc].dir == DOWN) ? A_W'(LAST_ADDR) : '0;
        state_nx    = op_is_wr(MARCH_TBL[elem_inc].op0) ? WR : RD;
      end else begin
        state_nx = DONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      elem        <= '0;
      op_idx      <= 1'b0;
      o_fail      <= 1'b0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
      o_fail_exp  <= '0;
    end else begin
      state  <= state_nx;
      elem   <= elem_nx;
      op_idx <= op_idx_nx;
      if (state == IDLE && i_start) begin
        o_fail      <= 1'b0;
        o_fail_addr <= '0;
        o_fail_data <= '0;
        o_fail_exp  <= '0;
      end else if (mismatch) begin
        o_fail      <= 1'b1;
        o_fail_addr <= addr;
        o_fail_data <= i_mem_out;
        o_fail_exp  <= pat;
      end
    end
  end

  assign o_busy        = (state == WR) || (state == RD) || (state == CMP);
  assign o_done        = (state == DONE);
  assign o_mem_en      = (state == WR) || (state == RD);
  assign o_mem_wr_rbar = (state == WR);
  assign o_mem_addr    = addr;
  assign o_mem_data    = (state == WR) ? pat : '0;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl with a 16-word memory model and injectable stuck-at bits.
module tb_mbist_march_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        o_busy, o_done, o_fail, o_mem_en, o_mem_wr_rbar;
  logic [15:0] o_fail_addr, o_mem_addr;
  logic [31:0] o_fail_data, o_fail_exp, o_mem_data;
  logic [31:0] i_mem_out = '0;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [16];
  int          flt_addr = -1;
  logic [31:0] sa1_mask = '0;
  logic [31:0] sa0_mask = '0;

  logic        tr_en   [1000];
  logic        tr_wr   [1000];
  logic [15:0] tr_addr [1000];
  logic [31:0] tr_data [1000];

  mbist_march_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail),
    .o_fail_addr(o_fail_addr), .o_fail_data(o_fail_data), .o_fail_exp(o_fail_exp),
    .o_mem_data(o_mem_data), .o_mem_addr(o_mem_addr), .o_mem_en(o_mem_en),
    .o_mem_wr_rbar(o_mem_wr_rbar), .i_mem_out(i_mem_out)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] fault(input logic [31:0] v, input int a);
    if (a == flt_addr) return (v | sa1_mask) & ~sa0_mask;
    return v;
  endfunction

  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_wr_rbar) mem[o_mem_addr[3:0]] <= fault(o_mem_data, int'(o_mem_addr[3:0]));
      else               i_mem_out <= fault(mem[o_mem_addr[3:0]], int'(o_mem_addr[3:0]));
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Accepts a start, then runs until o_done (bounded); cycle 1 is the first cycle after acceptance.
  task automatic run(input bit hold, output int cyc, output int bcnt, output logic busy_at_done);
    i_start = 1'b1;
    tick();
    if (!hold) i_start = 1'b0;
    cyc = 1;
    bcnt = 0;
    while (!o_done && cyc < 999) begin
      if (o_busy) bcnt++;
      tr_en[cyc] = o_mem_en; tr_wr[cyc] = o_mem_wr_rbar;
      tr_addr[cyc] = o_mem_addr; tr_data[cyc] = o_mem_data;
      tick();
      cyc++;
    end
    busy_at_done = o_busy;
  endtask

  int   cyc, bcnt, seen_done;
  logic bad_busy;

  initial begin
    foreach (mem[i]) mem[i] = '0;
    tick(); tick();
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_en",   64'(o_mem_en), 64'd0);
    chk("rst_fail", 64'(o_fail), 64'd0);
    chk("rst_addr", 64'(o_mem_addr), 64'd0);
    i_rst = 1'b0;
    tick();

    // Fault-free run
    run(1'b0, cyc, bcnt, bad_busy);
    chk("ok_done_cyc", 64'(cyc), 64'd241);
    chk("ok_busy_cnt", 64'(bcnt), 64'd240);
    chk("ok_busy_at_done", 64'(bad_busy), 64'd0);
    chk("ok_fail", 64'(o_fail), 64'd0);
    chk("c1_wr", {tr_en[1], tr_wr[1], tr_addr[1], tr_data[1]}, {1'b1, 1'b1, 16'd0, 32'd0});
    chk("c16_wr", {tr_en[16], tr_wr[16], tr_addr[16]}, {1'b1, 1'b1, 16'd15});
    chk("c17_rd", {tr_en[17], tr_wr[17], tr_addr[17]}, {1'b1, 1'b0, 16'd0});
    chk("c18_cmp", 64'(tr_en[18]), 64'd0);
    chk("c19_w1", {tr_en[19], tr_wr[19], tr_addr[19], tr_data[19]}, {1'b1, 1'b1, 16'd0, 32'hFFFFFFFF});
    chk("c113_dn_rd", {tr_en[113], tr_wr[113], tr_addr[113]}, {1'b1, 1'b0, 16'd15});
    chk("c116_dn_rd", {tr_en[116], tr_wr[116], tr_addr[116]}, {1'b1, 1'b0, 16'd14});
    chk("c209_e5_rd", {tr_en[209], tr_wr[209], tr_addr[209]}, {1'b1, 1'b0, 16'd0});
    chk("c240_cmp", {tr_en[240], tr_addr[240]}, {1'b0, 16'd15});
    tick();
    chk("idle_after", {o_busy, o_done}, 64'd0);

    // Bit 0 stuck-at-1 at address 5: caught by the first r0 in E1
    flt_addr = 5; sa1_mask = 32'h1; sa0_mask = '0;
    run(1'b0, cyc, bcnt, bad_busy);
    chk("sa1_done_cyc", 64'(cyc), 64'd34);
    chk("sa1_fail", 64'(o_fail), 64'd1);
    chk("sa1_addr", 64'(o_fail_addr), 64'd5);
    chk("sa1_data", 64'(o_fail_data), 64'h1);
    chk("sa1_exp",  64'(o_fail_exp), 64'h0);
    tick();
    chk("sa1_hold", {o_fail, o_fail_addr, o_fail_data}, {1'b1, 16'd5, 32'h1});

    // Restart after a failure clears the fail fields at the acceptance edge
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("clr_fail", {o_fail, o_fail_addr, o_fail_data, o_fail_exp}, 64'd0);
    chk("clr_busy", 64'(o_busy), 64'd1);
    cyc = 1;
    while (!o_done && cyc < 999) begin tick(); cyc++; end
    chk("refail_cyc", 64'(cyc), 64'd34);
    tick();

    // Start held high for the whole run: no restart while busy or in DONE
    flt_addr = -1; sa1_mask = '0;
    run(1'b1, cyc, bcnt, bad_busy);
    chk("hold_done_cyc", 64'(cyc), 64'd241);
    chk("hold_busy_cnt", 64'(bcnt), 64'd240);
    i_start = 1'b0;
    tick();
    chk("hold_idle", 64'(o_busy), 64'd0);
    tick();

    // Bit 31 stuck-at-0 at address 15: caught by r1 in E2
    flt_addr = 15; sa0_mask = 32'h80000000;
    run(1'b0, cyc, bcnt, bad_busy);
    chk("sa0_done_cyc", 64'(cyc), 64'd112);
    chk("sa0_addr", 64'(o_fail_addr), 64'd15);
    chk("sa0_data", 64'(o_fail_data), 64'h7FFFFFFF);
    chk("sa0_exp",  64'(o_fail_exp), 64'hFFFFFFFF);
    tick();

    // Reset 100 cycles into a run aborts it without o_done
    flt_addr = -1; sa0_mask = '0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (99) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("abort_outs", {o_busy, o_done, o_fail, o_fail_addr, o_fail_data, o_fail_exp,
                       o_mem_data, o_mem_addr, o_mem_en, o_mem_wr_rbar}, '0);
    seen_done = 0;
    repeat (20) begin
      if (o_done) seen_done++;
      tick();
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    run(1'b0, cyc, bcnt, bad_busy);
    chk("rerun_cyc", 64'(cyc), 64'd241);
    chk("rerun_busy", 64'(bcnt), 64'd240);
    chk("rerun_fail", 64'(o_fail), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
